spi_pcm_tx: RTL



---
 rtl/spi_pcm_tx_if.sv | 23 ++
 rtl/spi_pcm_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spi_pcm_tx_if.sv
// Host-side write port and serial PCM output bundle of the serial PCM transmitter.
// The master modport is the sample producer/observer; the slave modport is the transmitter.
interface spi_pcm_tx_if;
    logic [7:0] din;
    logic       wr;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       spi_sclk;
    logic       spi_fs;
    logic       spi_data;

    modport master (
        output din, wr,
        input  full, empty, ovf, busy, spi_sclk, spi_fs, spi_data
    );

    modport slave (
        input  din, wr,
        output full, empty, ovf, busy, spi_sclk, spi_fs, spi_data
    );
endinterface

// File: rtl/spi_pcm_tx.sv
// Serial PCM transmitter: buffers 8-bit mu-law samples in a FIFO and shifts them out MSB-first
// with a one-bit frame sync and a generated bit clock, back-to-back while samples are queued.
module spi_pcm_tx #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    spi_pcm_tx_if.slave  bus
);
    localparam int DW = $clog2(DIV);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            sclk_q, sclk_d;
    logic            fs_q, fs_d;
    logic            data_q, data_d;
    logic            tick_s;
    logic            push_s;
    logic            pop_s;

    assign tick_s = (div_cnt_q == DW'(DIV - 1));
    // full_q mirrors count_q == DEPTH, so a write seen while full is dropped even if a pop coincides.
    assign push_s = bus.wr && !full_q;

    // Next-state logic for divider, FSM, shifter, FIFO bookkeeping and output registers.
    always_comb begin
        div_cnt_d = tick_s ? {DW{1'b0}} : div_cnt_q + DW'(1);
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pop_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick_s && !empty_q) begin
                    pop_s     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = 3'd7;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!tick_s) begin
                    state_d = ST_SHIFT;
                end else if (bit_cnt_q != 3'd0) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end else if (!empty_q) begin
                    pop_s     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = 3'd7;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == {CW{1'b0}});
        ovf_d   = bus.wr && full_q;

        // Outputs follow next state so data/fs move on the same edge that drops sclk.
        busy_d = (state_d == ST_SHIFT);
        data_d = (state_d == ST_SHIFT) ? shift_d[7] : 1'b0;
        fs_d   = (state_d == ST_SHIFT) && (bit_cnt_d == 3'd7);
        sclk_d = (state_d == ST_SHIFT) && (div_cnt_d >= DW'(DIV / 2));
    end

    // State, FIFO and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= {DW{1'b0}};
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            fs_q      <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            fs_q      <= fs_d;
            data_q    <= data_d;
        end
    end

    // Sample storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_q[wr_ptr_q] <= bus.din;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_fs   = fs_q;
    assign bus.spi_data = data_q;
endmodule
